isa_bus_master: RTL and testbench

- Initiator end of the 8-bit ISA bus that the CGA card and other on-board peripherals respond to.
- Converts single-beat requests from the CPU/host side into timed ISA I/O or memory cycles: address setup, strobe, ready-extended wait, hold.
- Returns read data, or a timeout error, to the requester.
- Sits between the CPU bus interface and all ISA responders, including the CGA card, on the same clock.

---
 rtl/isa_bus_master.sv | 259 +++++++++++++++++++++++++
 tb/tb_isa_bus_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_bus_master.sv
// isa_bus_master: initiator for the 8-bit ISA bus.
// Turns one host request at a time into a timed ISA I/O or memory cycle:
// address setup, strobe (extended while the responder holds rdy low, with an
// optional timeout), then hold. Reports completion, read data and timeout.
//
// Ports:
//   clk, nRESET               clock, synchronous active-low reset
//   req_valid/req_ready       host request handshake
//   req_write, req_io         cycle type (write/read, I/O/memory)
//   req_addr, req_wdata       cycle address and write data
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      read data and timeout flag, valid with resp_valid
//   bus_a, bus_d_out, bus_d_oe  ISA address, write data and its drive enable
//   bus_d_in                  ISA read data
//   bus_ior_l ... bus_memw_l  active-low ISA strobes
//   bus_aen                   high = address not valid for I/O decode
//   bus_rdy                   responder ready, low extends the strobe
module isa_bus_master #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter logic [15:0] WAIT_TIMEOUT  = 16'd1024
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_err,
    output logic [19:0] bus_a,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic        bus_aen,
    input  logic        bus_rdy
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // Phase counter reload values: each phase counts down to zero.
    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);
    localparam logic       HOLD_ONE    = (HOLD_CYCLES == 32'd1);

    // Active-low strobe vector {memw, memr, iow, ior} for a cycle type.
    function automatic logic [3:0] strobe_sel(input logic io, input logic wr);
        logic [3:0] s;
        case ({io, wr})
            2'b10:   s = 4'b1110;
            2'b11:   s = 4'b1101;
            2'b00:   s = 4'b1011;
            2'b01:   s = 4'b0111;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [15:0] wait_q, wait_d;
    logic        rdy_q, rdy_d;
    logic        write_q, write_d;
    logic        io_q, io_d;
    logic        err_q, err_d;
    logic [7:0]  cap_q, cap_d;
    logic        req_ready_q, req_ready_d;
    logic [19:0] bus_a_q, bus_a_d;
    logic [7:0]  bus_d_out_q, bus_d_out_d;
    logic        bus_d_oe_q, bus_d_oe_d;
    logic [3:0]  strb_l_q, strb_l_d;
    logic        bus_aen_q, bus_aen_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [7:0]  resp_rdata_q, resp_rdata_d;
    logic        end_s;
    logic        timeout_s;

    // Next-state and next-output logic for the bus cycle sequencer.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        wait_d       = wait_q;
        rdy_d        = bus_rdy;
        write_d      = write_q;
        io_d         = io_q;
        err_d        = err_q;
        cap_d        = cap_q;
        req_ready_d  = req_ready_q;
        bus_a_d      = bus_a_q;
        bus_d_out_d  = bus_d_out_q;
        bus_d_oe_d   = bus_d_oe_q;
        strb_l_d     = strb_l_q;
        bus_aen_d    = bus_aen_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        end_s        = 1'b0;
        timeout_s    = 1'b0;

        case (state_q)
            IDLE: begin
                // req_ready is high throughout IDLE, so valid alone accepts.
                if (req_valid) begin
                    bus_a_d     = req_addr;
                    bus_d_out_d = req_wdata;
                    write_d     = req_write;
                    io_d        = req_io;
                    req_ready_d = 1'b0;
                    bus_aen_d   = 1'b0;
                    bus_d_oe_d  = req_write;
                    err_d       = 1'b0;
                    phase_d     = SETUP_LAST;
                    state_d     = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (phase_q == 4'd0) begin
                    strb_l_d = strobe_sel(io_q, write_q);
                    phase_d  = STROBE_LAST;
                    wait_d   = 16'd0;
                    state_d  = STROBE;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            STROBE: begin
                // Minimum width first, then wait on the registered ready.
                if (phase_q != 4'd0) begin
                    phase_d = phase_q - 4'd1;
                end else if (rdy_q) begin
                    end_s = 1'b1;
                end else if ((WAIT_TIMEOUT != 16'd0) && (wait_q == WAIT_TIMEOUT)) begin
                    end_s     = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            HOLD: begin
                if (phase_q == 4'd0) begin
                    req_ready_d = 1'b1;
                    bus_aen_d   = 1'b1;
                    bus_d_oe_d  = 1'b0;
                    state_d     = IDLE;
                end else begin
                    if (phase_q == 4'd1) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = err_q;
                        if (!write_q) begin
                            resp_rdata_d = cap_q;
                        end else begin
                            resp_rdata_d = resp_rdata_q;
                        end
                    end else begin
                        resp_valid_d = 1'b0;
                    end
                    phase_d = phase_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobe end: capture read data on this edge (forced on timeout).
        if (end_s) begin
            strb_l_d = 4'b1111;
            phase_d  = HOLD_LAST;
            err_d    = timeout_s;
            state_d  = HOLD;
            if (!write_q) begin
                cap_d = timeout_s ? 8'hFF : bus_d_in;
            end else begin
                cap_d = cap_q;
            end
            // A single hold cycle is also the last one, so respond now.
            if (HOLD_ONE) begin
                resp_valid_d = 1'b1;
                resp_err_d   = timeout_s;
                if (!write_q) begin
                    resp_rdata_d = cap_d;
                end else begin
                    resp_rdata_d = resp_rdata_q;
                end
            end else begin
                resp_valid_d = 1'b0;
            end
        end else begin
            end_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q      <= IDLE;
            phase_q      <= 4'd0;
            wait_q       <= 16'd0;
            rdy_q        <= 1'b1;
            write_q      <= 1'b0;
            io_q         <= 1'b0;
            err_q        <= 1'b0;
            cap_q        <= 8'h00;
            req_ready_q  <= 1'b1;
            bus_a_q      <= 20'h00000;
            bus_d_out_q  <= 8'h00;
            bus_d_oe_q   <= 1'b0;
            strb_l_q     <= 4'b1111;
            bus_aen_q    <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            wait_q       <= wait_d;
            rdy_q        <= rdy_d;
            write_q      <= write_d;
            io_q         <= io_d;
            err_q        <= err_d;
            cap_q        <= cap_d;
            req_ready_q  <= req_ready_d;
            bus_a_q      <= bus_a_d;
            bus_d_out_q  <= bus_d_out_d;
            bus_d_oe_q   <= bus_d_oe_d;
            strb_l_q     <= strb_l_d;
            bus_aen_q    <= bus_aen_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign bus_a      = bus_a_q;
    assign bus_d_out  = bus_d_out_q;
    assign bus_d_oe   = bus_d_oe_q;
    assign bus_ior_l  = strb_l_q[0];
    assign bus_iow_l  = strb_l_q[1];
    assign bus_memr_l = strb_l_q[2];
    assign bus_memw_l = strb_l_q[3];
    assign bus_aen    = bus_aen_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_isa_bus_master.sv
// Self-checking bench for isa_bus_master (default timing, WAIT_TIMEOUT = 8).
// Cycle n is the clock period that ends at edge n; the accept edge is edge 0.
module tb_isa_bus_master;

    localparam int S  = 2;
    localparam int ST = 4;
    localparam int H  = 1;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_io = 1'b0;
    logic [19:0] req_addr = 20'h0;
    logic [7:0]  req_wdata = 8'h0;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_err;
    logic [19:0] bus_a;
    logic [7:0]  bus_d_out;
    logic        bus_d_oe;
    logic [7:0]  bus_d_in = 8'h0;
    logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
    logic        bus_aen;
    logic        bus_rdy = 1'b1;

    isa_bus_master #(.WAIT_TIMEOUT(16'd8)) dut (
        .clk(clk), .nRESET(nRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_a(bus_a), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_aen(bus_aen), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic       is_rd;
        logic [7:0] rdata;
        logic       err;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered ready seen during cycle c: bus_rdy of cycle c-1.
    // bus_rdy is low in cycles 0..rl.
    function automatic int rq(input int c, input int rl);
        return (c - 1 <= rl) ? 0 : 1;
    endfunction

    // Last strobe-low cycle: minimum width, then extend while ready is low,
    // at most TO extra cycles.
    function automatic int exp_last(input int rl);
        int last;
        int extra;
        last  = S + ST;
        extra = 0;
        while (rq(last, rl) == 0 && extra < TO) begin
            last++;
            extra++;
        end
        return last;
    endfunction

    // Scoreboard: compare each completion against the oldest expectation.
    always @(negedge clk) begin : resp_mon
        exp_t e;
        logic [7:0] last_rd;
        if (!mon_en) begin
            last_rd = 8'h00;
        end else if (resp_valid) begin
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("resp_err", resp_err, e.err);
                if (e.is_rd) begin
                    check("resp_rdata", resp_rdata, e.rdata);
                    last_rd = e.rdata;
                end else begin
                    check("rdata_hold", resp_rdata, last_rd);
                end
            end
        end
    end

    // Strobe exclusivity and no strobe while the address is disabled.
    always @(negedge clk) begin : excl_mon
        int n;
        if (mon_en) begin
            n = 0;
            if (!bus_ior_l)  n++;
            if (!bus_iow_l)  n++;
            if (!bus_memr_l) n++;
            if (!bus_memw_l) n++;
            check("strobe_excl", 32'(n <= 1), 32'd1);
            if (bus_aen) check("strobe_vs_aen", 32'(n), 32'd0);
        end
    end

    task automatic run_txn(input logic wr, input logic io, input logic [19:0] addr,
                           input logic [7:0] wdata, input logic [7:0] din, input int rl);
        int first = 0, last = 0, cnt = 0, other = 0;
        int aen_first = 0, aen_last = 0, oe_cnt = 0, dout_bad = 0, a_bad = 0;
        int resp_c = 0, el;
        bit done = 0;
        logic tgt;
        int nlow;
        exp_t e;
        el = exp_last(rl);
        e.is_rd = !wr;
        e.err   = (rq(el, rl) == 0);
        e.rdata = e.err ? 8'hFF : din;
        sb_q.push_back(e);

        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_io = io; req_addr = addr; req_wdata = wdata;
        bus_rdy  = (0 <= rl) ? 1'b0 : 1'b1;
        bus_d_in = 8'hA0;
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            tgt  = io ? (wr ? bus_iow_l : bus_ior_l) : (wr ? bus_memw_l : bus_memr_l);
            nlow = 32'(!bus_ior_l) + 32'(!bus_iow_l) + 32'(!bus_memr_l) + 32'(!bus_memw_l);
            if (!tgt) begin
                if (first == 0) first = c;
                last = c;
                cnt++;
                nlow--;
            end
            other += nlow;
            if (!bus_aen) begin
                if (aen_first == 0) aen_first = c;
                aen_last = c;
            end
            if (bus_d_oe) oe_cnt++;
            if (wr && bus_d_out !== wdata) dout_bad++;
            if (bus_a !== addr) a_bad++;
            if (resp_c != 0 && c == resp_c + 1) begin
                check("req_ready_after", req_ready, 1'b1);
                check("d_oe_after", bus_d_oe, 1'b0);
                done = 1;
            end
            if (resp_valid && resp_c == 0) resp_c = c;
            bus_rdy  = (c <= rl) ? 1'b0 : 1'b1;
            bus_d_in = (c == el) ? din : {4'hA, 4'(c)};
        end
        bus_rdy = 1'b1;
        check("strobe_first", 32'(first), 32'(S + 1));
        check("strobe_last", 32'(last), 32'(el));
        check("strobe_contig", 32'(cnt), 32'(last - first + 1));
        check("other_strobes", 32'(other), 32'd0);
        check("aen_first", 32'(aen_first), 32'd1);
        check("aen_last", 32'(aen_last), 32'(el + H));
        check("resp_cycle", 32'(resp_c), 32'(el + H));
        check("d_oe_cycles", 32'(oe_cnt), wr ? 32'(el + H) : 32'd0);
        check("d_out_stable", 32'(dout_bad), 32'd0);
        check("addr_stable", 32'(a_bad), 32'd0);
    endtask

    initial begin
        int first_rdy, rdy_cnt, r1, r2;
        exp_t e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nRESET = 1'b1;
        check("rst_strobes", {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}, 4'hF);
        check("rst_aen", bus_aen, 1'b1);
        check("rst_d_oe", bus_d_oe, 1'b0);
        check("rst_bus_a", bus_a, 20'h0);
        check("rst_d_out", bus_d_out, 8'h00);
        check("rst_resp", {resp_valid, resp_err, resp_rdata}, 10'h000);
        check("rst_req_ready", req_ready, 1'b1);
        mon_en = 1'b1;

        // Reset in cycle 4 of an I/O write aborts it without a response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_io = 1'b1; req_addr = 20'h003D8; req_wdata = 8'h55;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (c == 4) check("pre_reset_iow", bus_iow_l, 1'b0);
            if (c == 4) nRESET = 1'b0;
        end
        @(negedge clk);
        check("mid_rst_strobes", {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}, 4'hF);
        check("mid_rst_aen", bus_aen, 1'b1);
        check("mid_rst_d_oe", bus_d_oe, 1'b0);
        check("mid_rst_resp", resp_valid, 1'b0);
        check("mid_rst_ready", req_ready, 1'b1);
        nRESET = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_iow", bus_iow_l, 1'b1);

        run_txn(1'b1, 1'b1, 20'h003D8, 8'h29, 8'h00, -1);   // I/O write
        run_txn(1'b0, 1'b1, 20'h003DA, 8'h00, 8'hF9, -1);   // I/O read
        run_txn(1'b0, 1'b0, 20'hB8000, 8'h00, 8'h5C, 9);    // memory read, ready low 0..9
        run_txn(1'b1, 1'b0, 20'hB8001, 8'hA5, 8'h00, 7);    // memory write with wait
        run_txn(1'b0, 1'b0, 20'hC0000, 8'h00, 8'h33, 1000); // timeout
        run_txn(1'b0, 1'b1, 20'h003DA, 8'h00, 8'h0C, 4);    // read after timeout

        // Back-to-back: valid held; second accepted when ready returns.
        e.is_rd = 1'b0; e.rdata = 8'h00; e.err = 1'b0; sb_q.push_back(e);
        e.is_rd = 1'b1; e.rdata = 8'h77; e.err = 1'b0; sb_q.push_back(e);
        first_rdy = 0; rdy_cnt = 0; r1 = 0; r2 = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_io = 1'b1; req_addr = 20'h003D4; req_wdata = 8'h0E;
        @(posedge clk);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_write = 1'b0; req_addr = 20'h003D5; req_wdata = 8'h00;
            end
            if (first_rdy != 0 && c == first_rdy + 1) req_valid = 1'b0;
            if (req_ready && c <= 15) rdy_cnt++;
            if (req_ready && first_rdy == 0) first_rdy = c;
            if (resp_valid && r1 == 0) r1 = c;
            else if (resp_valid && r2 == 0) r2 = c;
            bus_d_in = (c == 8 + S + ST) ? 8'h77 : {4'hB, 4'(c)};
        end
        check("b2b_ready_cycle", 32'(first_rdy), 32'(S + ST + H + 1));
        check("b2b_ready_count", 32'(rdy_cnt), 32'd1);
        check("b2b_resp1", 32'(r1), 32'(S + ST + H));
        check("b2b_resp2", 32'(r2), 32'(2 * (S + ST + H) + 1));
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
